// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// frame geometry, default baud timing and the 2-of-3 majority voter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int c_DATA_BITS              = 8;
  localparam int c_CLK_HZ                 = 50_000_000;
  localparam int c_BAUD                   = 115_200;
  localparam int c_DEFAULT_CYCLES_PER_BIT = c_CLK_HZ / c_BAUD;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count, full/empty flags and
// an overrun pulse for writes that arrive while full with no read.
// The head word reads as zero while empty so a freshly reset FIFO shows 0.
module sync_fifo #(
  parameter int c_WIDTH = 8,
  parameter int c_DEPTH = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       i_WR_EN,
  input  logic [c_WIDTH-1:0]         i_WR_DATA,
  input  logic                       i_RD_EN,
  output logic [c_WIDTH-1:0]         o_RD_DATA,
  output logic                       o_EMPTY,
  output logic                       o_FULL,
  output logic [$clog2(c_DEPTH):0]   o_COUNT,
  output logic                       o_OVERRUN
);

  localparam int c_PTR_W = $clog2(c_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL_COUNT = (c_PTR_W + 1)'(c_DEPTH);

  logic [c_WIDTH-1:0] mem [c_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr;
  logic [c_PTR_W-1:0] rd_ptr;
  logic [c_PTR_W:0]   count;
  logic               do_wr;
  logic               do_rd;

  assign o_EMPTY   = (count == '0);
  assign o_FULL    = (count == c_FULL_COUNT);
  assign o_COUNT   = count;
  assign do_rd     = i_RD_EN && !o_EMPTY;
  assign do_wr     = i_WR_EN && (!o_FULL || do_rd);
  assign o_OVERRUN = i_WR_EN && o_FULL && !do_rd;
  assign o_RD_DATA = o_EMPTY ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge i_CLK) begin
    if (do_wr) begin
      mem[wr_ptr] <= i_WR_DATA;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop input synchroniser, start-bit glitch rejection,
// 3-sample majority voting per bit, framing/overrun detection and an FWFT
// byte FIFO toward the host. Define UART_RX_PARITY_EN for 8E1 frames with
// an extra o_PARITY_ERR output; the default build receives 8N1.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT,
  parameter int c_FIFO_DEPTH     = 8
) (
  input  logic                            i_CLK,
  input  logic                            i_RESET,
  input  logic                            i_SERIAL_DATA,
  input  logic                            i_RD_EN,
  output logic [7:0]                      o_DATA,
  output logic                            o_EMPTY,
  output logic                            o_FULL,
  output logic [$clog2(c_FIFO_DEPTH):0]   o_COUNT,
  output logic                            o_FRAME_ERR,
  output logic                            o_OVERRUN
`ifdef UART_RX_PARITY_EN
  ,
  output logic                            o_PARITY_ERR
`endif
);

  localparam int c_CNT_W = $clog2(c_CYCLES_PER_BIT);
  localparam int c_MID   = c_CYCLES_PER_BIT / 2;
  localparam logic [c_CNT_W-1:0] c_SAMPLE_A = c_CNT_W'(c_MID - 1);
  localparam logic [c_CNT_W-1:0] c_SAMPLE_B = c_CNT_W'(c_MID);
  localparam logic [c_CNT_W-1:0] c_SAMPLE_C = c_CNT_W'(c_MID + 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(c_CYCLES_PER_BIT - 1);
  localparam logic [2:0]         c_LAST_BIT = 3'(c_DATA_BITS - 1);

  rx_state_t              state;
  rx_state_t              state_next;
  logic                   sync_meta;
  logic                   sync_q;
  logic                   sync_prev;
  logic [c_CNT_W-1:0]     cnt;
  logic [2:0]             bit_idx;
  logic                   samp_a;
  logic                   samp_b;
  logic [c_DATA_BITS-1:0] shift_reg;
  logic                   vote;
  logic                   sample_now;
  logic                   bit_end;
  logic                   fall_edge;
  logic                   fifo_wr;
  logic                   frame_err;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit;
  logic                   parity_err;
  assign o_PARITY_ERR = parity_err;
`endif

  assign vote        = majority3(samp_a, samp_b, sync_q);
  assign sample_now  = (cnt == c_SAMPLE_C);
  assign bit_end     = (cnt == c_BIT_LAST);
  assign fall_edge   = sync_prev && !sync_q;
  assign o_FRAME_ERR = frame_err;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Synchroniser, bit-period counter, early vote samples and shift register.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      sync_meta <= i_SERIAL_DATA;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
      if (state == IDLE || state == BREAK || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == c_SAMPLE_A) begin
        samp_a <= sync_q;
      end
      if (cnt == c_SAMPLE_B) begin
        samp_b <= sync_q;
      end
      if (state == DATA && sample_now) begin
        shift_reg <= {vote, shift_reg[c_DATA_BITS-1:1]};
      end
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && sample_now) begin
        parity_bit <= vote;
      end
`endif
    end
  end

  // Frame sequencing: next state plus single-cycle write and error strobes.
  always_comb begin
    state_next = state;
    fifo_wr    = 1'b0;
    frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
        end
      end
      START: begin
        if (sample_now && vote) begin
          state_next = IDLE;
        end else if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end && bit_idx == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (sample_now) begin
`ifdef UART_RX_PARITY_EN
          parity_err = ^{shift_reg, parity_bit};
          if (vote) begin
            fifo_wr    = !parity_err;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
`else
          if (vote) begin
            fifo_wr    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
`endif
        end
      end
      BREAK: begin
        if (sync_q) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .c_WIDTH (c_DATA_BITS),
    .c_DEPTH (c_FIFO_DEPTH)
  ) u_fifo (
    .i_CLK     (i_CLK),
    .i_RESET   (i_RESET),
    .i_WR_EN   (fifo_wr),
    .i_WR_DATA (shift_reg),
    .i_RD_EN   (i_RD_EN),
    .o_RD_DATA (o_DATA),
    .o_EMPTY   (o_EMPTY),
    .o_FULL    (o_FULL),
    .o_COUNT   (o_COUNT),
    .o_OVERRUN (o_OVERRUN)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 16 cycles per bit. A byte queue
// models the receive FIFO; serial frames are built bit by bit from the data.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          r_CLK = 1'b0;
  logic          r_RESET;
  logic          r_SERIAL_DATA;
  logic          r_RD_EN;
  logic [7:0]    w_DATA;
  logic          w_EMPTY;
  logic          w_FULL;
  logic [CW-1:0] w_COUNT;
  logic          w_FRAME_ERR;
  logic          w_OVERRUN;

  int checks         = 0;
  int errors         = 0;
  int frame_err_seen = 0;
  int overrun_seen   = 0;
  int frame_err_exp  = 0;
  int overrun_exp    = 0;
  logic [7:0] model_q [$];

  always #5 r_CLK = ~r_CLK;

  uart_rx_fifo #(
    .c_CYCLES_PER_BIT (CPB),
    .c_FIFO_DEPTH     (DEPTH)
  ) dut (
    .i_CLK         (r_CLK),
    .i_RESET       (r_RESET),
    .i_SERIAL_DATA (r_SERIAL_DATA),
    .i_RD_EN       (r_RD_EN),
    .o_DATA        (w_DATA),
    .o_EMPTY       (w_EMPTY),
    .o_FULL        (w_FULL),
    .o_COUNT       (w_COUNT),
    .o_FRAME_ERR   (w_FRAME_ERR),
    .o_OVERRUN     (w_OVERRUN)
  );

  // Count high cycles of each error strobe so a stretched pulse shows up as extra counts.
  always @(negedge r_CLK) begin
    if (w_FRAME_ERR) frame_err_seen += 1;
    if (w_OVERRUN)   overrun_seen   += 1;
  end

  // Hard bound on run time in case the design never settles.
  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: cycle budget exhausted, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks += 1;
    assert (observed === expected) else begin
      errors += 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic val, input int noise_at);
    for (int c = 0; c < CPB; c++) begin
      r_SERIAL_DATA = (c == noise_at) ? ~val : val;
      @(posedge r_CLK); #1;
    end
  endtask

  task automatic idle(input int n);
    r_SERIAL_DATA = 1'b1;
    repeat (n) begin
      @(posedge r_CLK); #1;
    end
  endtask

  task automatic model_write(input logic [7:0] data, input bit rd_same);
    if (rd_same && model_q.size() > 0) void'(model_q.pop_front());
    if (model_q.size() < DEPTH) model_q.push_back(data);
    else overrun_exp += 1;
  endtask

  // One 8N1 frame. The write strobe lands 156 cycles after the start bit is
  // driven (2 sync flops, 1 edge-detect cycle, 9 bit periods, mid+1 = 9),
  // which is stop-bit cycle 12; the byte becomes visible after cycle 13.
  task automatic applyStimulus(input logic [7:0] data, input int stop_low_bits,
                               input int noise_bit, input bit rd_on_write,
                               input bit check_latency);
    drive_bit(1'b0, -1);
    for (int b = 0; b < 8; b++) drive_bit(data[b], (b == noise_bit) ? CPB / 2 : -1);
    if (stop_low_bits > 0) begin
      for (int s = 0; s < stop_low_bits; s++) drive_bit(1'b0, -1);
      frame_err_exp += 1;
      drive_bit(1'b1, -1);
    end else begin
      r_SERIAL_DATA = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (c == 12) begin
          if (check_latency) checkOutput("empty_at_stop_sample", w_EMPTY, 1);
          if (rd_on_write) begin
            checkOutput("head_at_rd_wr", w_DATA, model_q[0]);
            r_RD_EN = 1'b1;
          end
        end
        if (c == 13) begin
          r_RD_EN = 1'b0;
          if (check_latency) checkOutput("empty_after_stop_sample", w_EMPTY, 0);
        end
        @(posedge r_CLK); #1;
      end
      model_write(data, rd_on_write);
    end
  endtask

  task automatic read_byte(input string tag);
    checkOutput(tag, w_DATA, model_q[0]);
    r_RD_EN = 1'b1;
    @(posedge r_CLK); #1;
    r_RD_EN = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic check_status(input string tag);
    checkOutput({tag, "_count"}, w_COUNT, model_q.size());
    checkOutput({tag, "_empty"}, w_EMPTY, model_q.size() == 0);
    checkOutput({tag, "_full"}, w_FULL, model_q.size() == DEPTH);
    checkOutput({tag, "_frame_err_pulses"}, frame_err_seen, frame_err_exp);
    checkOutput({tag, "_overrun_pulses"}, overrun_seen, overrun_exp);
    if (model_q.size() > 0) checkOutput({tag, "_head"}, w_DATA, model_q[0]);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_data"}, w_DATA, 8'h00);
    checkOutput({tag, "_empty"}, w_EMPTY, 1);
    checkOutput({tag, "_full"}, w_FULL, 0);
    checkOutput({tag, "_count"}, w_COUNT, 0);
    checkOutput({tag, "_frame_err"}, w_FRAME_ERR, 0);
    checkOutput({tag, "_overrun"}, w_OVERRUN, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] partial;
    int         nb;
    int         nr;
    bit         rdw;
    int         sl;

    r_RESET       = 1'b0;
    r_SERIAL_DATA = 1'b1;
    r_RD_EN       = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (3) @(posedge r_CLK);
    #1;
    r_RESET = 1'b1;
    idle(4);

    $display("[TB] single frame 0x27");
    applyStimulus(8'h27, 0, -1, 1'b0, 1'b1);
    idle(2);
    check_status("t1");
    read_byte("t1_read");
    check_status("t1_after_read");

    $display("[TB] start glitch and data-bit noise");
    r_SERIAL_DATA = 1'b0;
    repeat (4) begin
      @(posedge r_CLK); #1;
    end
    idle(40);
    check_status("glitch");
    applyStimulus(8'hA5, 0, 3, 1'b0, 1'b0);
    idle(2);
    check_status("noise");
    read_byte("noise_read");

    $display("[TB] framing error then recovery");
    applyStimulus(8'h55, 3, -1, 1'b0, 1'b0);
    idle(4);
    check_status("ferr");
    applyStimulus(8'h3C, 0, -1, 1'b0, 1'b0);
    idle(2);
    check_status("ferr_recover");
    read_byte("ferr_recover_read");

    $display("[TB] overrun");
    for (int v = 1; v <= 9; v++) begin
      applyStimulus(8'(v), 0, -1, 1'b0, 1'b0);
      if (v == 8) checkOutput("full_after_8", w_FULL, 1);
    end
    idle(2);
    check_status("overrun");
    while (model_q.size() > 0) read_byte("overrun_drain");
    check_status("overrun_drained");

    $display("[TB] read and write together while full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'h11 + 8'(i), 0, -1, 1'b0, 1'b0);
    applyStimulus(8'h09, 0, -1, 1'b1, 1'b0);
    idle(2);
    check_status("rdwr_full");
    while (model_q.size() > 0) read_byte("rdwr_drain");
    check_status("rdwr_drained");

    $display("[TB] reset during data bit 4");
    applyStimulus(8'h5A, 0, -1, 1'b0, 1'b0);
    idle(2);
    check_status("pre_reset");
    partial = 8'h96;
    drive_bit(1'b0, -1);
    for (int b = 0; b < 4; b++) drive_bit(partial[b], -1);
    r_SERIAL_DATA = partial[4];
    repeat (5) @(posedge r_CLK);
    #3;
    r_RESET = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    model_q.delete();
    r_SERIAL_DATA = 1'b1;
    repeat (3) @(posedge r_CLK);
    #1;
    r_RESET = 1'b1;
    idle(20);
    check_status("post_reset_idle");
    applyStimulus(8'hC3, 0, -1, 1'b0, 1'b0);
    idle(2);
    check_status("post_reset");
    read_byte("post_reset_read");

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom_range(0, 255));
      nb  = $urandom_range(0, 11);
      if (nb > 7) nb = -1;
      sl  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      rdw = (sl == 0) && (model_q.size() > 0) && ($urandom_range(0, 3) == 0);
      applyStimulus(d, sl, nb, rdw, 1'b0);
      idle($urandom_range(0, 6));
      check_status("rand");
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) begin
        if (model_q.size() > 0) read_byte("rand_read");
      end
    end
    while (model_q.size() > 0) read_byte("final_drain");
    idle(2);
    check_status("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver front-end for the game-controller link: deserialises 8N1 frames from the serial line and buffers received bytes in a small FIFO, so the host-side logic can drain bytes at its own pace.
- Adds start-bit glitch rejection, 3-sample majority voting, framing-error and overrun detection.
- Sits between the serial pin and the command-decode logic, as the receive counterpart of the existing transmitter.

Parameters:
c_CYCLES_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); must be >= 8.
c_FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
i_CLK  input  1  system clock, rising edge.
i_RESET  input  1  asynchronous, active-low reset.
i_SERIAL_DATA  input  1  asynchronous serial line; idle high.
i_RD_EN  input  1  pop head byte this cycle (ignored when o_EMPTY=1).
o_DATA  output  8  FIFO head byte, first-word fall-through; valid while o_EMPTY=0.
o_EMPTY  output  1  FIFO empty.
o_FULL  output  1  FIFO full.
o_COUNT  output  $clog2(c_FIFO_DEPTH)+1  occupancy.
o_FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
o_OVERRUN  output  1  one-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Reset (i_RESET=0, asynchronous):
  - FSM=IDLE; FIFO pointers and count=0.
  - o_DATA=8'h00, o_EMPTY=1, o_FULL=0, o_COUNT=0, o_FRAME_ERR=0, o_OVERRUN=0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame; no partial byte is written.
- Input path: 2-flop synchroniser; all logic uses the synchronised signal.
- Majority vote: each bit value is the 2-of-3 vote of samples at cycle offsets mid-1, mid, mid+1 of the bit, where mid = c_CYCLES_PER_BIT/2 (integer divide).
- Bit counter: a single cycle counter restarts at 0 at each bit boundary.
- FSM states:
  - IDLE: on a synchronised falling edge, go to START with counter=0.
  - START: at mid+1, evaluate the vote. If the vote is 1, it is a glitch: return to IDLE with no output. If 0, go to DATA at the end of the bit period.
  - DATA: 8 bits, LSB first, each voted at mid+1 and shifted into the shift register; after bit 7 ends, go to STOP.
  - STOP: at mid+1, evaluate the vote.
    - Vote=1: request a FIFO write, then return to IDLE immediately (this allows back-to-back frames).
    - Vote=0: pulse o_FRAME_ERR, discard the byte, go to BREAK.
  - BREAK: wait until the synchronised line is 1, then go to IDLE.
- Latency: o_EMPTY falls on the cycle after the stop-bit mid+1 sample (FIFO previously empty).
- FIFO:
  - Write with FIFO not full: store the byte, count+1.
  - Write with FIFO full and no read in the same cycle: drop the byte, pulse o_OVERRUN, contents unchanged.
  - Read with i_RD_EN=1 and o_EMPTY=0: head advances, count-1, next byte appears on o_DATA the following cycle.
  - Read while empty: no effect.
  - Simultaneous read and write: count unchanged. This is legal even when full (no overrun) and when empty is not possible at the same cycle: the write is seen at the next cycle.
  - Pointers wrap modulo c_FIFO_DEPTH.
  - o_FULL = (count == c_FIFO_DEPTH).

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frame is 8E1. A parity bit follows data bit 7 and is voted like the data bits.
  - If parity is not even: discard the byte and pulse o_PARITY_ERR (extra 1-bit output port present only with the macro).
  - The stop-bit check still applies. A frame with both errors pulses both flags.
- Undefined: 8N1, no parity state, no o_PARITY_ERR port.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), c_DATA_BITS=8, default baud constants.
- One sub-module, sync_fifo: parameterised width/depth FWFT FIFO with count, full and empty.
- The receiver FSM, synchroniser and voter stay in uart_rx_fifo.

Test Plan:
Run all scenarios with c_CYCLES_PER_BIT=16 to keep simulation short.
1. Single frame 8'h27: o_EMPTY falls one cycle after the stop mid+1 sample; o_DATA=8'h27, o_COUNT=1; i_RD_EN pulse -> o_EMPTY=1, o_COUNT=0.
2. Start glitch: line low for 4 cycles, then high -> FSM back in IDLE, o_COUNT stays 0, no error pulses. Noise: single-cycle inversion at mid of a data bit in a 8'hA5 frame -> 8'hA5 received.
3. Framing error: send 8'h55 with the stop bit held low for 3 bits -> o_FRAME_ERR one-cycle pulse, no write; after line returns high, a following 8'h3C is received correctly.
4. Overrun: send 9 back-to-back frames 8'h01..8'h09 with no reads -> o_FULL=1 after 8'h08; 8'h09 gives an o_OVERRUN pulse; drain yields 8'h01..8'h08 in order, with wrap verified on a second fill.
5. Simultaneous read and write at full: hold i_RD_EN on the write cycle of the 9th frame -> no overrun, o_COUNT stays 8, last entry=8'h09.
6. Reset mid-frame: assert i_RESET=0 during data bit 4 -> all outputs at reset values immediately; after release, the next 8'hC3 frame is received correctly.
